fpu_req_arbiter: RTL and testbench
==================================

// Module: fpu_req_arbiter
// PURPOSE
//  Shares one CVFPU instance among NUM_REQ requesters (e.g. per-warp issue slots).
//  - Round-robin arbitration with per-requester outstanding-op credit limit.
//  - Registers the winning request into a one-entry issue stage that drives the FPU.
//  - Extends the FPU tag with the requester id; routes responses back by that id.
// PARAMETERS
//  WIDTH       512  FPU operand/result width (LANES*32)
//  NUM_REQ     4    number of requesters, >=2, power of 2
//  USER_TAG_W  4    requester-private tag width, returned unchanged
//  MAX_OUT     4    max ops in flight per requester (stage reg + FPU), >=1
//  ID_W        $clog2(NUM_REQ) (derived); FPU tag width = ID_W+USER_TAG_W
// PORTS
//  clock              in   1                    single clock, rising edge
//  reset_n            in   1                    asynchronous, active-low reset
//  req_valid          in   NUM_REQ              per-requester request valid
//  req_ready          out  NUM_REQ              per-requester accept
//  req_operands       in   NUM_REQ*3*WIDTH      {op2,op1,op0} per requester
//  req_ctrl           in   NUM_REQ*32           {simdMask16,rm3,op5,src3,dst3,int2} per requester
//  req_tag            in   NUM_REQ*USER_TAG_W   requester tag
//  resp_valid         out  NUM_REQ              one-hot response valid
//  resp_ready         in   NUM_REQ              per-requester response accept
//  resp_result        out  WIDTH                broadcast result
//  resp_status        out  5                    broadcast fflags
//  resp_tag           out  USER_TAG_W           broadcast user tag
//  fpu_req_*          out  -                    to CVFPU req_bits_*/req_valid (tag = {id,user})
//  fpu_req_ready      in   1                    CVFPU req_ready
//  fpu_resp_*         in   -                    from CVFPU result/status/tag/valid
//  fpu_resp_ready     out  1                    to CVFPU resp_ready
//  flush              in   1                    sync flush; forwarded to CVFPU flush
//  busy               out  1                    stage valid | any credit count != 0
// BEHAVIOUR
//  Reset: stage_valid=0, rr_ptr=0, all cnt[i]=0; req_ready=0, resp_valid=0,
//   fpu_req_valid=0, busy=0.
//  Eligible i: req_valid[i] && cnt[i]<MAX_OUT. Winner: first eligible at/after rr_ptr.
//  Stage loads when (!stage_valid || fpu_req_ready) && !flush; req_ready[winner]=1 then,
//   other req_ready=0 (req_ready may depend on req_valid). rr_ptr <= winner+1 mod NUM_REQ on load.
//  fpu_req_valid = stage_valid; stage payload is stable while valid && !fpu_req_ready.
//  Request latency: accept in cycle t -> fpu_req_valid in t+1. Back-to-back at full rate.
//  cnt[i] +1 on load for i, -1 on response handshake (fpu_resp_valid&&resp_ready[id])
//   for i; both same cycle -> unchanged. cnt never exceeds MAX_OUT and never underflows;
//   a response to an id with cnt==0 is an assertion error.
//  Response: id=fpu_resp_tag[MSBs]; resp_valid = fpu_resp_valid one-hot at id;
//   fpu_resp_ready = resp_ready[id]. Purely combinational, 0 cycles.
//  flush=1: stage_valid<=0, all cnt<=0, no load that cycle, rr_ptr held; responses
//   are suppressed (resp_valid=0, fpu_resp_ready=1) during the flush cycle.
//  Reset asserted mid-operation: all state cleared asynchronously; in-flight ops lost.
//  No eligible requester: stage drains, rr_ptr held.
// STRUCTURE
//  Shared package fpu_arb_pkg: fpu_ctrl_t struct (simdMask, rm, op, src/dst/int fmt),
//   ID_W function, fpu_tag_t = {id,user}.
//  One sub-module: rr_arbiter (NUM_REQ, mask-in, ptr-in -> one-hot grant + index).
//  Credit counters, issue stage, response demux in this module.
// TESTING
//  1. Reset then idle -> all outputs 0, busy=0.
//  2. NUM_REQ=4, all req_valid held, fpu_req_ready=1 -> issue ids 0,1,2,3,0... one per cycle.
//  3. Req 2 only, responses withheld -> exactly MAX_OUT=4 accepts, then req_ready[2]=0;
//     one response to id 2 -> next cycle req_ready[2]=1.
//  4. fpu_req_ready=0 for 3 cycles with stage full -> fpu_req_* stable, no req_ready.
//  5. Same cycle: load id1 and response id1 with cnt[1]=2 -> cnt[1] stays 2.
//  6. flush with cnt={1,3,0,2}, stage full -> next cycle stage empty, cnt all 0, busy=0.

Source files
------------

// File: rtl/fpu_arb_pkg.sv
// Shared types and helpers for the FPU request arbiter.
package fpu_arb_pkg;

  typedef struct packed {
    logic [15:0] simd_mask;
    logic [2:0]  rm;
    logic [4:0]  op;
    logic [2:0]  src_fmt;
    logic [2:0]  dst_fmt;
    logic [1:0]  int_fmt;
  } fpu_ctrl_t;

  function automatic int unsigned id_w(input int unsigned num_req);
    return (num_req > 1) ? $clog2(num_req) : 1;
  endfunction

  localparam int unsigned DEF_NUM_REQ    = 4;
  localparam int unsigned DEF_USER_TAG_W = 4;

  // FPU tag layout for the default configuration: requester id above the user tag.
  typedef struct packed {
    logic [id_w(DEF_NUM_REQ)-1:0] id;
    logic [DEF_USER_TAG_W-1:0]    user;
  } fpu_tag_t;

endpackage

// File: rtl/fpu_req_arbiter_rr.sv
// Round-robin pick: first set mask bit at or after ptr, as one-hot grant plus index.
module rr_arbiter
  import fpu_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = id_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] mask,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    idx,
  output logic               any
);

  logic [ID_W-1:0] cand;

  // NUM_REQ is a power of two, so ptr+k wraps naturally in ID_W bits.
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    cand  = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = ptr + ID_W'(k);
      if (!any && mask[cand]) begin
        any         = 1'b1;
        grant[cand] = 1'b1;
        idx         = cand;
      end
    end
  end

endmodule

// File: rtl/fpu_req_arbiter.sv
// Shares one FPU among NUM_REQ requesters: round-robin issue with per-requester
// credit limits, one-entry issue stage, and id-tagged response routing.
module fpu_req_arbiter
  import fpu_arb_pkg::*;
#(
  parameter int unsigned WIDTH      = 512,
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned USER_TAG_W = 4,
  parameter int unsigned MAX_OUT    = 4
) (
  input  logic                                clock,
  input  logic                                reset_n,
  input  logic [NUM_REQ-1:0]                  req_valid,
  output logic [NUM_REQ-1:0]                  req_ready,
  input  logic [NUM_REQ*3*WIDTH-1:0]          req_operands,
  input  logic [NUM_REQ*32-1:0]               req_ctrl,
  input  logic [NUM_REQ*USER_TAG_W-1:0]       req_tag,
  output logic [NUM_REQ-1:0]                  resp_valid,
  input  logic [NUM_REQ-1:0]                  resp_ready,
  output logic [WIDTH-1:0]                    resp_result,
  output logic [4:0]                          resp_status,
  output logic [USER_TAG_W-1:0]               resp_tag,
  output logic                                fpu_req_valid,
  input  logic                                fpu_req_ready,
  output logic [3*WIDTH-1:0]                  fpu_req_operands,
  output logic [31:0]                         fpu_req_ctrl,
  output logic [id_w(NUM_REQ)+USER_TAG_W-1:0] fpu_req_tag,
  input  logic                                fpu_resp_valid,
  output logic                                fpu_resp_ready,
  input  logic [WIDTH-1:0]                    fpu_resp_result,
  input  logic [4:0]                          fpu_resp_status,
  input  logic [id_w(NUM_REQ)+USER_TAG_W-1:0] fpu_resp_tag,
  input  logic                                flush,
  output logic                                fpu_flush,
  output logic                                busy
);

  localparam int unsigned ID_W  = id_w(NUM_REQ);
  localparam int unsigned CNT_W = $clog2(MAX_OUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUT);

  typedef struct packed {
    logic [ID_W-1:0]       id;
    logic [USER_TAG_W-1:0] user;
  } tag_t;

  logic                  stage_valid;
  logic [3*WIDTH-1:0]    stage_ops;
  fpu_ctrl_t             stage_ctrl;
  tag_t                  stage_tag;
  logic [ID_W-1:0]       rr_ptr;
  logic [CNT_W-1:0]      cnt [NUM_REQ];

  logic [NUM_REQ-1:0]    eligible;
  logic [NUM_REQ-1:0]    grant;
  logic [ID_W-1:0]       win;
  logic                  win_any;
  logic                  load_en;
  logic                  load;
  logic [NUM_REQ-1:0]    cnt_inc;
  logic [NUM_REQ-1:0]    resp_hs;
  logic                  cnt_nz;
  tag_t                  rtag;
  logic [3*WIDTH-1:0]    sel_ops;
  fpu_ctrl_t             sel_ctrl;
  logic [USER_TAG_W-1:0] sel_tag;

  always_comb begin
    eligible = '0;
    cnt_nz   = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      eligible[i] = req_valid[i] && (cnt[i] < CNT_MAX);
      cnt_nz      = cnt_nz | (cnt[i] != '0);
    end
  end

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr (
    .mask  (eligible),
    .ptr   (rr_ptr),
    .grant (grant),
    .idx   (win),
    .any   (win_any)
  );

  assign load_en   = (!stage_valid || fpu_req_ready) && !flush;
  assign load      = load_en && win_any;
  assign req_ready = load_en ? grant : '0;
  assign cnt_inc   = load ? grant : '0;

  always_comb begin
    sel_ops  = '0;
    sel_ctrl = '0;
    sel_tag  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_ops  = req_operands[i*3*WIDTH +: 3*WIDTH];
        sel_ctrl = req_ctrl[i*32 +: 32];
        sel_tag  = req_tag[i*USER_TAG_W +: USER_TAG_W];
      end
    end
  end

  // Responses are dropped (accepted, not forwarded) while flushing.
  assign rtag = fpu_resp_tag;
  always_comb begin
    resp_valid     = '0;
    resp_hs        = '0;
    fpu_resp_ready = resp_ready[rtag.id];
    if (flush) begin
      fpu_resp_ready = 1'b1;
    end else if (fpu_resp_valid) begin
      resp_valid[rtag.id] = 1'b1;
      resp_hs[rtag.id]    = resp_ready[rtag.id];
    end
  end

  assign resp_result      = fpu_resp_result;
  assign resp_status      = fpu_resp_status;
  assign resp_tag         = rtag.user;
  assign fpu_req_valid    = stage_valid;
  assign fpu_req_operands = stage_ops;
  assign fpu_req_ctrl     = stage_ctrl;
  assign fpu_req_tag      = stage_tag;
  assign fpu_flush        = flush;
  assign busy             = stage_valid | cnt_nz;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stage_valid <= 1'b0;
      stage_ops   <= '0;
      stage_ctrl  <= '0;
      stage_tag   <= '0;
      rr_ptr      <= '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) cnt[i] <= '0;
    end else if (flush) begin
      stage_valid <= 1'b0;
      for (int unsigned i = 0; i < NUM_REQ; i++) cnt[i] <= '0;
    end else begin
      if (load) begin
        stage_valid <= 1'b1;
        stage_ops   <= sel_ops;
        stage_ctrl  <= sel_ctrl;
        stage_tag   <= '{id: win, user: sel_tag};
        rr_ptr      <= win + ID_W'(1);
      end else if (fpu_req_ready) begin
        stage_valid <= 1'b0;
      end
      // Simultaneous issue and retire for one requester leaves its count unchanged.
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (cnt_inc[i] && !resp_hs[i]) cnt[i] <= cnt[i] + CNT_W'(1);
        else if (!cnt_inc[i] && resp_hs[i] && cnt[i] != '0) cnt[i] <= cnt[i] - CNT_W'(1);
      end
    end
  end

  resp_credit_chk: assert property (@(posedge clock) disable iff (!reset_n)
    (fpu_resp_valid && !flush && resp_ready[rtag.id]) |-> (cnt[rtag.id] != '0));

endmodule

// File: tb/tb_fpu_req_arbiter.sv
// Randomized bench for fpu_req_arbiter with a queue-based credit/issue model.
module tb_fpu_req_arbiter;

  localparam int N   = 4;
  localparam int W   = 64;
  localparam int UT  = 4;
  localparam int MO  = 4;
  localparam int IDW = 2;
  localparam int TW  = IDW + UT;

  logic              clock = 1'b0;
  logic              reset_n;
  logic [N-1:0]      req_valid;
  logic [N-1:0]      req_ready;
  logic [N*3*W-1:0]  req_operands;
  logic [N*32-1:0]   req_ctrl;
  logic [N*UT-1:0]   req_tag;
  logic [N-1:0]      resp_valid;
  logic [N-1:0]      resp_ready;
  logic [W-1:0]      resp_result;
  logic [4:0]        resp_status;
  logic [UT-1:0]     resp_tag;
  logic              fpu_req_valid;
  logic              fpu_req_ready;
  logic [3*W-1:0]    fpu_req_operands;
  logic [31:0]       fpu_req_ctrl;
  logic [TW-1:0]     fpu_req_tag;
  logic              fpu_resp_valid;
  logic              fpu_resp_ready;
  logic [W-1:0]      fpu_resp_result;
  logic [4:0]        fpu_resp_status;
  logic [TW-1:0]     fpu_resp_tag;
  logic              flush;
  logic              fpu_flush;
  logic              busy;

  fpu_req_arbiter #(
    .WIDTH      (W),
    .NUM_REQ    (N),
    .USER_TAG_W (UT),
    .MAX_OUT    (MO)
  ) dut (
    .clock            (clock),
    .reset_n          (reset_n),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_operands     (req_operands),
    .req_ctrl         (req_ctrl),
    .req_tag          (req_tag),
    .resp_valid       (resp_valid),
    .resp_ready       (resp_ready),
    .resp_result      (resp_result),
    .resp_status      (resp_status),
    .resp_tag         (resp_tag),
    .fpu_req_valid    (fpu_req_valid),
    .fpu_req_ready    (fpu_req_ready),
    .fpu_req_operands (fpu_req_operands),
    .fpu_req_ctrl     (fpu_req_ctrl),
    .fpu_req_tag      (fpu_req_tag),
    .fpu_resp_valid   (fpu_resp_valid),
    .fpu_resp_ready   (fpu_resp_ready),
    .fpu_resp_result  (fpu_resp_result),
    .fpu_resp_status  (fpu_resp_status),
    .fpu_resp_tag     (fpu_resp_tag),
    .flush            (flush),
    .fpu_flush        (fpu_flush),
    .busy             (busy)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;

  // Model: in-flight count per requester, pointer, stage contents, FPU queue of tags.
  int           m_cnt [N];
  int           m_ptr;
  bit           m_sv;
  logic [3*W-1:0] m_ops;
  logic [31:0]  m_ctrl;
  logic [TW-1:0] m_tag;
  logic [TW-1:0] fq [$];
  bit           resp_en;
  int           exp_w;
  bit           exp_le;
  logic [IDW-1:0] rid;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic int winner();
    for (int k = 0; k < N; k++) begin
      int j;
      j = (m_ptr + k) % N;
      if (req_valid[j] && m_cnt[j] < MO) return j;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_sv = 0;
    m_ptr = 0;
    for (int i = 0; i < N; i++) m_cnt[i] = 0;
    fq.delete();
  endtask

  task automatic rand_payload();
    for (int i = 0; i < N*3*W/32; i++) req_operands[i*32 +: 32] = $urandom;
    for (int i = 0; i < N; i++) req_ctrl[i*32 +: 32] = $urandom;
    req_tag = N*UT'($urandom);
  endtask

  task automatic settle();
    int busy_exp;
    fpu_resp_valid  = resp_en && (fq.size() > 0);
    fpu_resp_tag    = (fq.size() > 0) ? fq[0] : '0;
    fpu_resp_result = {$urandom, $urandom};
    fpu_resp_status = 5'($urandom);
    #1;
    exp_w  = winner();
    exp_le = (!m_sv || fpu_req_ready) && !flush;
    chk("req_ready", req_ready, (exp_le && exp_w >= 0) ? (1 << exp_w) : 0);
    rid = fpu_resp_tag[TW-1:UT];
    chk("resp_valid", resp_valid, (fpu_resp_valid && !flush) ? (1 << rid) : 0);
    chk("fpu_resp_ready", fpu_resp_ready, flush ? 1'b1 : resp_ready[rid]);
    if (fpu_resp_valid && !flush) begin
      chk("resp_tag", resp_tag, fpu_resp_tag[UT-1:0]);
      chk("resp_result", resp_result, fpu_resp_result);
      chk("resp_status", resp_status, fpu_resp_status);
    end
    chk("fpu_req_valid", fpu_req_valid, m_sv);
    if (m_sv) begin
      chk("fpu_req_operands", fpu_req_operands, m_ops);
      chk("fpu_req_ctrl", fpu_req_ctrl, m_ctrl);
      chk("fpu_req_tag", fpu_req_tag, m_tag);
    end
    busy_exp = m_sv;
    for (int i = 0; i < N; i++) if (m_cnt[i] > 0) busy_exp = 1;
    chk("busy", busy, busy_exp[0]);
    chk("fpu_flush", fpu_flush, flush);
  endtask

  task automatic advance();
    if (flush) begin
      m_sv = 0;
      for (int i = 0; i < N; i++) m_cnt[i] = 0;
      fq.delete();
    end else begin
      if (fpu_resp_valid && resp_ready[rid]) begin
        m_cnt[rid]--;
        void'(fq.pop_front());
      end
      if (m_sv && fpu_req_ready) fq.push_back(m_tag);
      if (exp_le && exp_w >= 0) begin
        m_cnt[exp_w]++;
        m_sv   = 1;
        m_ops  = req_operands[exp_w*3*W +: 3*W];
        m_ctrl = req_ctrl[exp_w*32 +: 32];
        m_tag  = {IDW'(exp_w), req_tag[exp_w*UT +: UT]};
        m_ptr  = (exp_w + 1) % N;
      end else if (fpu_req_ready) begin
        m_sv = 0;
      end
    end
    @(negedge clock);
  endtask

  task automatic flush_cycle();
    flush = 1; req_valid = '0; resp_en = 0;
    settle();
    advance();
    flush = 0;
  endtask

  initial begin
    int acc;
    reset_n = 0; req_valid = '0; req_operands = '0; req_ctrl = '0; req_tag = '0;
    resp_ready = '0; fpu_req_ready = 0; flush = 0; resp_en = 0;
    fpu_resp_valid = 0; fpu_resp_tag = '0; fpu_resp_result = '0; fpu_resp_status = '0;
    model_reset();
    repeat (3) @(negedge clock);
    reset_n = 1;

    // Reset then idle.
    settle();
    chk("t1_req_ready", req_ready, 0);
    chk("t1_resp_valid", resp_valid, 0);
    chk("t1_fpu_req_valid", fpu_req_valid, 0);
    chk("t1_busy", busy, 0);
    advance();

    // All requesting at full FPU rate: 0,1,2,3,0,...
    rand_payload();
    req_valid = '1; fpu_req_ready = 1;
    for (int c = 0; c < 8; c++) begin
      settle();
      chk("t2_grant", req_ready, 1 << (c % 4));
      if (c > 0) chk("t2_issue_id", fpu_req_tag[TW-1:UT], (c - 1) % 4);
      advance();
    end
    // Flush with stage full and credits outstanding.
    flush_cycle();
    settle();
    chk("t6_busy", busy, 0);
    chk("t6_stage_empty", fpu_req_valid, 0);
    advance();

    // Credit limit on requester 2.
    req_valid = 4'b0100;
    for (int c = 0; c < 6; c++) begin
      rand_payload();
      settle();
      chk("t3_credit", req_ready, (c < 4) ? 4'b0100 : 4'b0000);
      advance();
    end
    resp_en = 1; resp_ready = 4'b0100;
    settle();
    chk("t3_resp_valid", resp_valid, 4'b0100);
    chk("t3_still_full", req_ready, 0);
    advance();
    resp_en = 0;
    settle();
    chk("t3_credit_back", req_ready, 4'b0100);
    advance();
    flush_cycle();

    // FPU stall holds the stage.
    req_valid = 4'b0010; fpu_req_ready = 0;
    settle();
    chk("t4_first_load", req_ready, 4'b0010);
    advance();
    for (int c = 0; c < 3; c++) begin
      rand_payload();
      settle();
      chk("t4_no_ready", req_ready, 0);
      chk("t4_valid_held", fpu_req_valid, 1);
      advance();
    end
    fpu_req_ready = 1; req_valid = '0;
    settle();
    advance();

    // Load and retire of id 1 in the same cycle with two outstanding.
    req_valid = 4'b0010;
    settle();
    advance();
    resp_en = 1; resp_ready = 4'b0010;
    settle();
    chk("t5_load", req_ready, 4'b0010);
    chk("t5_resp", resp_valid, 4'b0010);
    advance();
    resp_en = 0;
    acc = 0;
    for (int c = 0; c < 4; c++) begin
      settle();
      if (req_ready[1]) acc++;
      advance();
    end
    chk("t5_credits_left", acc, 2);
    flush_cycle();

    // Randomized traffic, with one asynchronous reset in the middle.
    for (int i = 0; i < 3000; i++) begin
      req_valid     = N'($urandom);
      rand_payload();
      fpu_req_ready = ($urandom % 4) != 0;
      resp_ready    = N'($urandom);
      resp_en       = ($urandom % 3) != 0;
      flush         = ($urandom % 50) == 0;
      settle();
      advance();
      if (i == 1500) begin
        #3 reset_n = 0;
        #1;
        chk("async_reset_valid", fpu_req_valid, 0);
        chk("async_reset_busy", busy, 0);
        model_reset();
        req_valid = '0; flush = 0; resp_en = 0;
        @(negedge clock);
        reset_n = 1;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
